puf_response_gen: RTL and testbench

PUF_RESPONSE_GEN -- requirements
Module: puf_response_gen

---
 rtl/puf_response_gen_pkg.sv | 17 +
 rtl/puf_response_gen_count_sync.sv | 25 ++
 rtl/puf_response_gen.sv | 129 ++++++++++++
 tb/tb_puf_response_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/puf_response_gen_pkg.sv
// Shared types and widths for the ring-oscillator PUF response generator.
package puf_response_gen_pkg;

  localparam int CHAL_W = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DECIDE = 3'd5,
    ST_DONE   = 3'd6
  } puf_state_t;

endpackage

// File: rtl/puf_response_gen_count_sync.sv
// puf_count_sync: free-running 2-flop synchroniser for an oscillator edge-count bus.
module puf_count_sync
  import puf_response_gen_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_response_gen.sv
// Ring-oscillator PUF: per bit, clear counters, run both oscillator banks, compare counts.
// Optional tie-flag output (tie_mask) is enabled by defining PUF_TIE_FLAG_EN.
module puf_response_gen
  import puf_response_gen_pkg::*;
#(
  parameter int WINDOW_CYCLES = 256,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESP_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge_base,
  output logic [CHAL_W-1:0]    sel,
  output logic                 ro_en,
  output logic                 cnt_clr,
  input  logic [CNT_W-1:0]     count_a,
  input  logic [CNT_W-1:0]     count_b,
  output logic                 busy,
  output logic                 valid,
  output logic [2:0]           state_dbg,
  output logic [RESP_BITS-1:0] response
`ifdef PUF_TIE_FLAG_EN
  ,
  output logic [RESP_BITS-1:0] tie_mask
`endif
);

  localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int KW   = $clog2(RESP_BITS + 1);

  puf_state_t          state, state_next;
  logic [TW-1:0]       timer;
  logic [KW-1:0]       k;
  logic [CHAL_W-1:0]   base_q;
  logic [RESP_BITS-1:0] sr, sr_next;
  logic [CNT_W-1:0]    sync_a, sync_b, cnt_a_q, cnt_b_q;
  logic                bit_d;

  puf_count_sync #(.W(CNT_W)) u_sync_a (.clk(clk), .rst_n(rst_n), .d(count_a), .q(sync_a));
  puf_count_sync #(.W(CNT_W)) u_sync_b (.clk(clk), .rst_n(rst_n), .d(count_b), .q(sync_b));

  // Handshake: start is a one-cycle request taken only in IDLE (ignored otherwise,
  // including the DONE/valid cycle); busy covers CLEAR..DECIDE; valid pulses for the
  // single DONE cycle, when response already holds the new word.
  assign cnt_clr   = (state == ST_CLEAR);
  assign ro_en     = (state == ST_RUN);
  assign valid     = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign state_dbg = state;
  assign sel       = base_q + CHAL_W'(k);

  // Unsigned compare; equal counts fall out as 0.
  assign bit_d   = (cnt_a_q > cnt_b_q);
  assign sr_next = (sr << 1) | RESP_BITS'(bit_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_CLEAR;
      ST_CLEAR:  if (timer == TW'(1)) state_next = ST_RUN;
      ST_RUN:    if (timer == TW'(WINDOW_CYCLES - 1)) state_next = ST_SETTLE;
      ST_SETTLE: if (timer == TW'(SETTLE_CYCLES - 1)) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = ST_DECIDE;
      ST_DECIDE: state_next = (k == KW'(RESP_BITS - 1)) ? ST_DONE : ST_CLEAR;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      k        <= '0;
      base_q   <= '0;
      sr       <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      response <= '0;
    end else begin
      timer <= (state_next != state) ? '0 : timer + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q <= challenge_base;
            k      <= '0;
            sr     <= '0;
          end
        end
        ST_SAMPLE: begin
          cnt_a_q <= sync_a;
          cnt_b_q <= sync_b;
        end
        ST_DECIDE: begin
          k  <= k + 1'b1;
          sr <= sr_next;
          if (state_next == ST_DONE) response <= sr_next;
        end
        default: ;
      endcase
    end
  end

`ifdef PUF_TIE_FLAG_EN
  logic [RESP_BITS-1:0] tie_sr, tie_next;

  assign tie_next = (tie_sr << 1) | RESP_BITS'(cnt_a_q == cnt_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_sr   <= '0;
      tie_mask <= '0;
    end else begin
      if (state == ST_IDLE && start) tie_sr <= '0;
      if (state == ST_DECIDE) begin
        tie_sr <= tie_next;
        if (state_next == ST_DONE) tie_mask <= tie_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_puf_response_gen.sv
// Directed self-checking bench for puf_response_gen (default parameters).
module tb_puf_response_gen;
  import puf_response_gen_pkg::*;

  localparam int WIN = 256;
  localparam int SET = 4;
  localparam int RB  = 8;
  // CLEAR(2) + RUN + SETTLE + SAMPLE(1) + DECIDE(1) per bit, then the DONE cycle.
  localparam int LAT = RB * (2 + WIN + SET + 2) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    challenge_base = '0;
  logic [4:0]    sel;
  logic          ro_en, cnt_clr, busy, valid;
  logic [7:0]    count_a, count_b;
  logic [2:0]    state_dbg;
  logic [RB-1:0] response;
`ifdef PUF_TIE_FLAG_EN
  logic [RB-1:0] tie_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int         mode = 0;
  logic [4:0] cur_base = '0;
  logic [4:0] kk;

  puf_response_gen #(.WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .RESP_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge_base(challenge_base),
    .sel(sel), .ro_en(ro_en), .cnt_clr(cnt_clr), .count_a(count_a), .count_b(count_b),
    .busy(busy), .valid(valid), .state_dbg(state_dbg), .response(response)
`ifdef PUF_TIE_FLAG_EN
    , .tie_mask(tie_mask)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Oscillator-bank model: counts depend on the challenge offset currently selected.
  always_comb begin
    kk = sel - cur_base;
    count_a = 8'd0;
    count_b = 8'd0;
    case (mode)
      0: begin count_a = 8'd200; count_b = 8'd100; end
      1: begin count_a = kk[0] ? 8'd150 : 8'd90; count_b = kk[0] ? 8'd90 : 8'd150; end
      2: begin count_a = 8'd77;  count_b = 8'd77;  end
      default: begin count_a = kk[0] ? 8'd0 : 8'd255; count_b = kk[0] ? 8'd255 : 8'd0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver + per-cycle monitor for one full run.
  task automatic run_test(input string tag, input logic [4:0] base, input int mode_i,
                          input logic [7:0] exp_resp, input logic [7:0] exp_tie, input bit poke);
    int n, clr_len, en_len, clr_runs, en_runs, bad_clr, bad_en, overlap, extra;
    bit got, busy_mid;
    logic [4:0] sel_q[$];
    mode = mode_i;
    cur_base = base;
    n = 0; clr_len = 0; en_len = 0; clr_runs = 0; en_runs = 0;
    bad_clr = 0; bad_en = 0; overlap = 0; extra = 0; got = 0; busy_mid = 0;
    @(negedge clk);
    challenge_base = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!got && n < LAT + 50) begin
      if (valid) got = 1;
      else begin
        if (cnt_clr && ro_en) overlap++;
        if (cnt_clr) begin
          if (clr_len == 0) sel_q.push_back(sel);
          clr_len++;
        end else if (clr_len != 0) begin
          clr_runs++;
          if (clr_len != 2) bad_clr++;
          clr_len = 0;
        end
        if (ro_en) en_len++;
        else if (en_len != 0) begin
          en_runs++;
          if (en_len != WIN) bad_en++;
          en_len = 0;
        end
        if (n == 50) busy_mid = busy;
        start = (poke && n == 100);
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    check({tag, ":valid_seen"}, 32'(got), 32'd1);
    check({tag, ":latency"}, n, LAT);
    check({tag, ":response"}, response, exp_resp);
`ifdef PUF_TIE_FLAG_EN
    check({tag, ":tie_mask"}, tie_mask, exp_tie);
`else
    if (exp_tie === 8'hxx) $display("note: unused tie expectation");
`endif
    check({tag, ":busy_mid"}, 32'(busy_mid), 32'd1);
    check({tag, ":clr_runs"}, clr_runs, RB);
    check({tag, ":en_runs"}, en_runs, RB);
    check({tag, ":bad_clr_len"}, bad_clr, 0);
    check({tag, ":bad_en_len"}, bad_en, 0);
    check({tag, ":clr_en_overlap"}, overlap, 0);
    check({tag, ":sel_count"}, sel_q.size(), RB);
    for (int i = 0; i < RB && i < sel_q.size(); i++)
      check({tag, ":sel"}, sel_q[i], 32'(5'(base + 5'(i))));
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":valid_one_cycle"}, 32'(valid), 32'd0);
    check({tag, ":idle_after"}, state_dbg, 32'(ST_IDLE));
    if (poke) begin
      for (int i = 0; i < 20; i++) begin
        if (valid || busy || cnt_clr) extra++;
        @(posedge clk); #1;
      end
      check({tag, ":no_extra_run"}, extra, 0);
    end
  endtask

  initial begin
    int clr_rise, spins, stray;
    logic prev_clr;
    // Reset state
    #23;
    check("rst:state", state_dbg, 32'(ST_IDLE));
    check("rst:ro_en", ro_en, 0);
    check("rst:cnt_clr", cnt_clr, 0);
    check("rst:busy", busy, 0);
    check("rst:valid", valid, 0);
    check("rst:sel", sel, 0);
    check("rst:response", response, 0);
`ifdef PUF_TIE_FLAG_EN
    check("rst:tie_mask", tie_mask, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_test("all_ones", 5'd5, 0, 8'hFF, 8'h00, 1'b1);
    run_test("odd_wrap", 5'd30, 1, 8'h55, 8'h00, 1'b0);
    run_test("ties", 5'd12, 2, 8'h00, 8'hFF, 1'b0);
    run_test("extremes", 5'd28, 3, 8'hAA, 8'h00, 1'b0);

    // Reset during the RUN phase of bit k=3
    mode = 0;
    cur_base = 5'd3;
    @(negedge clk);
    challenge_base = 5'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clr_rise = 0; spins = 0; prev_clr = 1'b0;
    while (!(clr_rise == 4 && ro_en) && spins < LAT) begin
      if (cnt_clr && !prev_clr) clr_rise++;
      prev_clr = cnt_clr;
      @(posedge clk); #1;
      spins++;
    end
    check("midrst:reached_k3", 32'(spins < LAT), 1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst:state", state_dbg, 32'(ST_IDLE));
    check("midrst:ro_en", ro_en, 0);
    check("midrst:response", response, 0);
    check("midrst:sel", sel, 0);
    check("midrst:busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (valid || busy || ro_en) stray++;
    end
    check("midrst:no_activity", stray, 0);

    run_test("after_rst", 5'd0, 1, 8'h55, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
